mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the core (fetch, load and store on behalf of the control FSM) and the debug/loader port (program preload and memory inspection).
- Sits between the requesters and the memory macro.
- Serialises accesses: one transaction in flight.
- Uses round-robin arbitration on conflict.
- Sequences the memory's fixed read latency and returns read data with a one-cycle valid pulse.

Parameters:
- ADDR_W, 32, address width in bits (matches addr_t).
- DATA_W, 32, data width in bits (matches data_t).
- MEM_LAT, 1, memory read latency in cycles, from address presented to rdata valid. Legal range 1..4; out-of-range values are an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core request valid; held with its fields until core_ready.
- core_we  in  1  core request is a write.
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core write data.
- core_ready  out  1  core request accepted this cycle (combinational).
- core_rvalid  out  1  one-cycle completion pulse for the core transaction.
- core_rdata  out  DATA_W  core read data; valid with core_rvalid.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ready, dbg_rvalid, dbg_rdata: same directions, widths and meanings for the debug/loader port.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_we  out  1  memory write enable (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, latency counter = 0, last_grant = DBG (so the core wins the first conflict).
  - All outputs are 0: mem_addr, mem_we, mem_wdata, both rvalid, both rdata.
  - Reset mid-transaction aborts it: mem_we drops immediately and no rvalid is issued.
- States: IDLE and BUSY.
- IDLE:
  - If any req is high, the arbiter grants exactly one requester and asserts that requester's ready (combinational from state and reqs).
  - On the clock edge it latches addr, we, wdata and owner into mem_addr, mem_we, mem_wdata and owner, loads the counter with MEM_LAT-1, and moves to BUSY.
  - With no req, it stays in IDLE with mem_we=0 and mem_addr holding its last value.
- Arbitration:
  - Only one requester high: that one is granted, independent of last_grant.
  - Both high: the requester not equal to last_grant is granted.
  - last_grant updates to the granted requester on every grant.
  - Both ready signals are never high together.
  - Ready is never asserted outside IDLE.
- BUSY:
  - mem_we is high only in the first BUSY cycle; the write commits at the edge ending that cycle. mem_we is cleared at the next edge.
  - mem_addr is stable for the whole of BUSY.
  - The counter decrements each cycle.
  - When the counter is 0: capture mem_rdata into the owner's rdata register, pulse the owner's rvalid in the next cycle, and return to IDLE.
  - Writes also produce an rvalid pulse (acknowledge). For a write, the owner's rdata holds its previous value.
- Latency and throughput:
  - A request accepted at cycle t gives rvalid at t+MEM_LAT+1.
  - The IDLE cycle that carries rvalid may accept a new request, so throughput is one transaction per MEM_LAT+1 cycles.
- rdata registers hold their value until the next read for the same port.
- A req that drops before ready is ignored; no transaction occurs.
- Changing fields while req is high and ready is low is a protocol violation; the bench asserts on it.
- Addresses pass through unchanged: no alignment check and no wrap handling.

Decomposition:
- Add to types.svh:
  - arb_state_t enum: ARB_STATE__IDLE, ARB_STATE__BUSY.
  - requester_t enum: REQUESTER__CORE, REQUESTER__DBG.
  - Reuse addr_t and data_t for the default widths.
- One sub-module: rr_arbiter2, a 2-way round-robin grant with a last_grant register and a grant-enable input. The FSM, latency counter and response steering stay in mem_arbiter.

Test Plan:
- Reset then a single core read at addr 0x10, with the memory model returning 0xDEADBEEF (MEM_LAT=1): core_ready high in cycle 0; mem_addr=0x10 in cycle 1; core_rvalid=1 with core_rdata=0xDEADBEEF in cycle 2; dbg_rvalid stays 0.
- Dbg write 0x12345678 to 0x20, then core read of 0x20: mem_we high for exactly one cycle. The core read returns 0x12345678. The dbg_rvalid ack arrives in cycle 2 and core_rdata is unchanged by the write.
- core_req and dbg_req both held high for 4 transactions after reset: grants alternate core, dbg, core, dbg, with ready asserted in cycles 0, 2, 4, 6.
- MEM_LAT=3 read: mem_addr is stable for cycles 1..3 and rvalid arrives at cycle 4. A new request asserted in cycle 2 gets ready only in cycle 4.
- Reset asserted in the first BUSY cycle of a write: mem_we falls to 0 asynchronously, no rvalid is pulsed, and after release the state is IDLE with last_grant=DBG.
- Back-to-back core reads with req held: ready arrives every 2 cycles (MEM_LAT=1). The rvalid pulse and the next ready coincide in the same cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Types and constants shared by the unified-memory arbiter, its interface and its sub-module.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_LAT    = 4;
    localparam int CNT_W      = 2;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic {
        ARB_STATE__IDLE,
        ARB_STATE__BUSY
    } arb_state_t;

    typedef enum logic {
        REQUESTER__CORE,
        REQUESTER__DBG
    } requester_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request fields, ready, and the read/ack response.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester that did not win last time wins a conflict.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req_core,
    input  logic       req_dbg,
    output logic       gnt_valid,
    output requester_t gnt_id,
    output logic       gnt_core,
    output logic       gnt_dbg
);
    requester_t last_grant;

    always_comb begin
        gnt_id = REQUESTER__CORE;
        if (req_core && req_dbg) begin
            gnt_id = (last_grant == REQUESTER__CORE) ? REQUESTER__DBG : REQUESTER__CORE;
        end else if (req_dbg) begin
            gnt_id = REQUESTER__DBG;
        end
    end

    assign gnt_valid = en && (req_core || req_dbg);
    assign gnt_core  = gnt_valid && (gnt_id == REQUESTER__CORE);
    assign gnt_dbg   = gnt_valid && (gnt_id == REQUESTER__DBG);

    // Reset to DBG so the core wins the first conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQUESTER__DBG;
        end else if (gnt_valid) begin
            last_grant <= gnt_id;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and debug/loader accesses onto one memory, sequencing its fixed read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = $bits(addr_t),
    parameter int DATA_W  = $bits(data_t),
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      core,
    mem_arbiter_if.slave      dbg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    if (MEM_LAT < 1 || MEM_LAT > MAX_LAT) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT must be in 1..4");
    end

    arb_state_t        state;
    requester_t        owner;
    logic              owner_we;
    logic [CNT_W-1:0]  lat_cnt;
    logic              core_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              gnt_valid;
    logic              gnt_core;
    logic              gnt_dbg;
    requester_t        gnt_id;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .en        (state == ARB_STATE__IDLE),
        .req_core  (core.req),
        .req_dbg   (dbg.req),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_core  (gnt_core),
        .gnt_dbg   (gnt_dbg)
    );

    assign core.ready  = gnt_core;
    assign dbg.ready   = gnt_dbg;
    assign core.rvalid = core_rvalid_q;
    assign dbg.rvalid  = dbg_rvalid_q;
    assign core.rdata  = core_rdata_q;
    assign dbg.rdata   = dbg_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARB_STATE__IDLE;
            owner         <= REQUESTER__CORE;
            owner_we      <= 1'b0;
            lat_cnt       <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            case (state)
                ARB_STATE__IDLE: begin
                    if (gnt_valid) begin
                        if (gnt_id == REQUESTER__CORE) begin
                            mem_addr  <= core.addr;
                            mem_we    <= core.we;
                            mem_wdata <= core.wdata;
                            owner_we  <= core.we;
                        end else begin
                            mem_addr  <= dbg.addr;
                            mem_we    <= dbg.we;
                            mem_wdata <= dbg.wdata;
                            owner_we  <= dbg.we;
                        end
                        owner   <= gnt_id;
                        lat_cnt <= CNT_W'(MEM_LAT - 1);
                        state   <= ARB_STATE__BUSY;
                    end
                end
                ARB_STATE__BUSY: begin
                    // The write commits at the edge ending the first BUSY cycle.
                    mem_we <= 1'b0;
                    if (lat_cnt == '0) begin
                        state <= ARB_STATE__IDLE;
                        if (owner == REQUESTER__CORE) begin
                            core_rvalid_q <= 1'b1;
                            if (!owner_we) core_rdata_q <= mem_rdata;
                        end else begin
                            dbg_rvalid_q <= 1'b1;
                            if (!owner_we) dbg_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                default: state <= ARB_STATE__IDLE;
            endcase
        end
    end
endmodule
